// File: rtl/vy_paket.sv
// vy_paket: shared state encoding and width helpers for the multi-channel block controller
package vy_paket;
  typedef enum logic [2:0] {BOSTA, OKU_ISTEK, OKU_BEKLE, OKU_YANIT, YAZ} durum_t;
  localparam logic HIGH = 1'b1;
  localparam logic LOW = 1'b0;
  function automatic int veri_byte(input int veri_bit);
    return veri_bit / 8;
  endfunction
  function automatic int blok_ofset(input int blok_bit);
    return $clog2(blok_bit / 8);
  endfunction
  function automatic int kelime_ofset(input int veri_bit);
    return $clog2(veri_bit / 8);
  endfunction
endpackage

// File: rtl/vy_rr_hakem.sv
// vy_rr_hakem: round-robin grant over request lines; pointer moves past the winner on accept
module vy_rr_hakem #(
  parameter int KANAL_SAYISI = 2,
  localparam int ID_BIT = (KANAL_SAYISI > 1) ? $clog2(KANAL_SAYISI) : 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [KANAL_SAYISI-1:0] istek_i,
  input  logic                    kabul_i,
  output logic [KANAL_SAYISI-1:0] grant_o,
  output logic [ID_BIT-1:0]       id_o
);
  logic [ID_BIT-1:0] p;
  logic [ID_BIT-1:0] j;
  logic bulundu;
  always_comb begin
    grant_o = '0;
    id_o = '0;
    bulundu = 1'b0;
    j = '0;
    for (int i = 0; i < KANAL_SAYISI; i++) begin
      j = ID_BIT'((int'(p) + i) % KANAL_SAYISI);
      if (!bulundu && istek_i[j]) begin
        grant_o[j] = 1'b1;
        id_o = j;
        bulundu = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) p <= '0;
    else if (kabul_i) p <= (id_o == ID_BIT'(KANAL_SAYISI - 1)) ? '0 : id_o + 1'b1;
  end
endmodule

// File: rtl/vy_coklu_denetleyici.sv
// vy_coklu_denetleyici: arbitrates L1 block requests onto a word-wide memory port
// VY_KRITIK_KELIME_EN: reads start at the requested word and wrap inside the block
module vy_coklu_denetleyici
  import vy_paket::*;
#(
  parameter int KANAL_SAYISI = 2,
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT = 32,
  parameter int BLOK_BIT = 128,
  localparam int KANAL_ID_BIT = (KANAL_SAYISI > 1) ? $clog2(KANAL_SAYISI) : 1
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [KANAL_SAYISI*ADRES_BIT-1:0] l1_istek_adres_i,
  input  logic [KANAL_SAYISI*BLOK_BIT-1:0]  l1_istek_veri_i,
  input  logic [KANAL_SAYISI-1:0]        l1_istek_yaz_i,
  input  logic [KANAL_SAYISI-1:0]        l1_istek_gecerli_i,
  output logic [KANAL_SAYISI-1:0]        l1_istek_hazir_o,
  output logic [BLOK_BIT-1:0]            l1_veri_o,
  output logic [KANAL_ID_BIT-1:0]        l1_veri_kanal_o,
  output logic [KANAL_SAYISI-1:0]        l1_veri_gecerli_o,
  input  logic [KANAL_SAYISI-1:0]        l1_veri_hazir_i,
  output logic [ADRES_BIT-1:0]           mem_istek_adres_o,
  output logic [VERI_BIT-1:0]            mem_istek_veri_o,
  output logic                           mem_istek_yaz_o,
  output logic                           mem_istek_gecerli_o,
  input  logic                           mem_istek_hazir_i,
  input  logic [VERI_BIT-1:0]            mem_veri_i,
  input  logic                           mem_veri_gecerli_i,
  output logic                           mem_veri_hazir_o
);
  localparam int VERI_BYTE = veri_byte(VERI_BIT);
  localparam int BLOK_VERI_SAYISI = BLOK_BIT / VERI_BIT;
  localparam int SAY_BIT = $clog2(BLOK_VERI_SAYISI);
  localparam logic [ADRES_BIT-1:0] BLOK_MASKE = ADRES_BIT'(BLOK_BIT / 8 - 1);
  localparam logic [SAY_BIT-1:0] SON = SAY_BIT'(BLOK_VERI_SAYISI - 1);
  durum_t durum;
  logic bosta_r, el, don, son_istek, son_donus;
  logic [KANAL_SAYISI-1:0] grant;
  logic [KANAL_ID_BIT-1:0] id;
  logic [ADRES_BIT-1:0] sec_adres, ilk_adres, sonraki_adres;
  logic [BLOK_BIT-1:0] sec_blok, blok_r, tampon_r, tampon_y;
  logic [SAY_BIT-1:0] idx, ridx, bas_r, bas_y, poz;
  vy_rr_hakem #(.KANAL_SAYISI(KANAL_SAYISI)) hakem (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .istek_i(l1_istek_gecerli_i),
    .kabul_i(el),
    .grant_o(grant),
    .id_o(id)
  );
  assign l1_istek_hazir_o = {KANAL_SAYISI{bosta_r}} & grant;
  assign el = bosta_r & |grant;
  assign sec_adres = l1_istek_adres_i[id*ADRES_BIT +: ADRES_BIT];
  assign sec_blok = l1_istek_veri_i[id*BLOK_BIT +: BLOK_BIT];
  assign don = mem_veri_gecerli_i & mem_veri_hazir_o;
  assign son_istek = idx == SON;
  assign son_donus = ridx == SON;
  assign poz = bas_r + ridx;
`ifdef VY_KRITIK_KELIME_EN
  localparam int OB = blok_ofset(BLOK_BIT);
  localparam int KB = kelime_ofset(VERI_BIT);
  assign ilk_adres = sec_adres & ~ADRES_BIT'(VERI_BYTE - 1);
  assign bas_y = sec_adres[OB-1:KB];
  // word offset wraps inside the block, block base stays fixed
  assign sonraki_adres = (mem_istek_adres_o & ~BLOK_MASKE) |
                         ((mem_istek_adres_o + ADRES_BIT'(VERI_BYTE)) & BLOK_MASKE);
`else
  assign ilk_adres = sec_adres & ~BLOK_MASKE;
  assign bas_y = '0;
  assign sonraki_adres = mem_istek_adres_o + ADRES_BIT'(VERI_BYTE);
`endif
  always_comb begin
    tampon_y = tampon_r;
    tampon_y[poz*VERI_BIT +: VERI_BIT] = mem_veri_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      durum <= BOSTA;
      bosta_r <= LOW;
      blok_r <= '0;
      tampon_r <= '0;
      idx <= '0;
      ridx <= '0;
      bas_r <= '0;
      l1_veri_o <= '0;
      l1_veri_kanal_o <= '0;
      l1_veri_gecerli_o <= '0;
      mem_istek_adres_o <= '0;
      mem_istek_veri_o <= '0;
      mem_istek_yaz_o <= LOW;
      mem_istek_gecerli_o <= LOW;
      mem_veri_hazir_o <= LOW;
    end else begin
      bosta_r <= (durum == BOSTA) & ~el;
      if (don) begin
        tampon_r <= tampon_y;
        ridx <= ridx + 1'b1;
      end
      case (durum)
        BOSTA: if (el) begin
          l1_veri_kanal_o <= id;
          blok_r <= sec_blok;
          idx <= '0;
          ridx <= '0;
          mem_istek_gecerli_o <= HIGH;
          mem_istek_veri_o <= sec_blok[VERI_BIT-1:0];
          if (l1_istek_yaz_i[id]) begin
            mem_istek_adres_o <= sec_adres & ~BLOK_MASKE;
            mem_istek_yaz_o <= HIGH;
            bas_r <= '0;
            durum <= YAZ;
          end else begin
            mem_istek_adres_o <= ilk_adres;
            mem_veri_hazir_o <= HIGH;
            bas_r <= bas_y;
            durum <= OKU_ISTEK;
          end
        end
        OKU_ISTEK, OKU_BEKLE: begin
          if (durum == OKU_ISTEK && mem_istek_hazir_i) begin
            mem_istek_adres_o <= sonraki_adres;
            idx <= idx + 1'b1;
            if (son_istek) begin
              mem_istek_gecerli_o <= LOW;
              durum <= OKU_BEKLE;
            end
          end
          // with zero-latency memory the last word can land while still issuing
          if (don && son_donus) begin
            l1_veri_o <= tampon_y;
            l1_veri_gecerli_o <= KANAL_SAYISI'(1) << l1_veri_kanal_o;
            mem_veri_hazir_o <= LOW;
            durum <= OKU_YANIT;
          end
        end
        OKU_YANIT: if (l1_veri_hazir_i[l1_veri_kanal_o]) begin
          l1_veri_gecerli_o <= '0;
          durum <= BOSTA;
        end
        YAZ: if (mem_istek_hazir_i) begin
          mem_istek_adres_o <= sonraki_adres;
          idx <= idx + 1'b1;
          mem_istek_veri_o <= blok_r[(idx + 1'b1)*VERI_BIT +: VERI_BIT];
          if (son_istek) begin
            mem_istek_gecerli_o <= LOW;
            mem_istek_yaz_o <= LOW;
            durum <= BOSTA;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end
endmodule
